// File: rtl/spi_note_sender.sv
// SPI-master serializer for note events: shifts a 2-byte NOTEOFF or 4-byte NOTEON
// frame MSB-first in SPI mode 0, with SCLK derived from i_clk by division.
module spi_note_sender #(
    parameter int          CLK_DIV  = 4,
    parameter int          BYTE_GAP = 8,
    parameter logic [7:0]  NOTEON   = 8'h90,
    parameter logic [7:0]  NOTEOFF  = 8'h80
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_note_status,
    input  logic [7:0] i_voice_index,
    input  logic [6:0] i_midi_note,
    input  logic [6:0] i_velocity,
    output logic       o_SPI_sclk,
    output logic       o_SPI_mosi,
    output logic       o_SPI_cs_n,
    output logic       o_done
);

    localparam int CNT_MAX = (CLK_DIV > BYTE_GAP) ? CLK_DIV : BYTE_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(BYTE_GAP - 1);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, GAP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic [1:0]    byte_last;
    logic [31:0]   shift_reg;

    // Handshake: a request is taken on any rising edge where i_valid and o_ready
    // are both high; o_ready stays low for the whole frame, so requests seen while
    // busy are simply not taken and the requester must keep i_valid asserted.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            byte_last  <= '0;
            shift_reg  <= '0;
            o_ready    <= 1'b1;
            o_SPI_sclk <= 1'b0;
            o_SPI_mosi <= 1'b0;
            o_SPI_cs_n <= 1'b1;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        if (i_note_status) begin
                            shift_reg <= {NOTEON, i_voice_index, 1'b0, i_midi_note,
                                          1'b0, i_velocity};
                            byte_last <= 2'd3;
                        end else begin
                            shift_reg <= {NOTEOFF, i_voice_index, 16'h0000};
                            byte_last <= 2'd1;
                        end
                        o_SPI_mosi <= i_note_status ? NOTEON[7] : NOTEOFF[7];
                        o_SPI_cs_n <= 1'b0;
                        o_SPI_sclk <= 1'b0;
                        o_ready    <= 1'b0;
                        cnt        <= '0;
                        bit_cnt    <= '0;
                        byte_cnt   <= '0;
                        state      <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (cnt == DIV_LAST) begin
                        cnt        <= '0;
                        o_SPI_sclk <= 1'b1;
                        state      <= SHIFT_HI;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (cnt == DIV_LAST) begin
                        cnt        <= '0;
                        o_SPI_sclk <= 1'b0;
                        shift_reg  <= {shift_reg[30:0], 1'b0};
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            // Next bit goes out on the falling edge.
                            bit_cnt    <= bit_cnt + 1'b1;
                            o_SPI_mosi <= shift_reg[30];
                            state      <= SHIFT_LO;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (byte_cnt == byte_last) begin
                            byte_cnt   <= '0;
                            o_SPI_cs_n <= 1'b1;
                            o_SPI_mosi <= 1'b0;
                            o_ready    <= 1'b1;
                            o_done     <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            byte_cnt   <= byte_cnt + 1'b1;
                            o_SPI_mosi <= shift_reg[31];
                            state      <= SHIFT_LO;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_note_sender.sv
// Bench for spi_note_sender: default-timing and fastest-timing instances, bytes
// reassembled from SCLK rises and checked against a queue of expected frames.
module tb_spi_note_sender;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a_valid = 1'b0, a_status = 1'b0;
    logic [7:0] a_voice = '0;
    logic [6:0] a_note = '0, a_vel = '0;
    logic       a_ready, a_sclk, a_mosi, a_cs_n, a_done;

    logic       b_valid = 1'b0, b_status = 1'b0;
    logic [7:0] b_voice = '0;
    logic [6:0] b_note = '0, b_vel = '0;
    logic       b_ready, b_sclk, b_mosi, b_cs_n, b_done;

    spi_note_sender dut_a (
        .i_clk(clk), .i_reset(rst), .i_valid(a_valid), .o_ready(a_ready),
        .i_note_status(a_status), .i_voice_index(a_voice), .i_midi_note(a_note),
        .i_velocity(a_vel), .o_SPI_sclk(a_sclk), .o_SPI_mosi(a_mosi),
        .o_SPI_cs_n(a_cs_n), .o_done(a_done)
    );

    spi_note_sender #(.CLK_DIV(1), .BYTE_GAP(1)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_valid(b_valid), .o_ready(b_ready),
        .i_note_status(b_status), .i_voice_index(b_voice), .i_midi_note(b_note),
        .i_velocity(b_vel), .o_SPI_sclk(b_sclk), .o_SPI_mosi(b_mosi),
        .o_SPI_cs_n(b_cs_n), .o_done(b_done)
    );

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         done_q[$];
    logic       prev_sclk[2];
    logic [7:0] acc[2];
    int         nbits[2];
    int         rises[2];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input int k, input logic sclk, input logic mosi, input logic done,
                       input logic cs_n, input logic ready);
        if (rst) begin
            prev_sclk[k] = 1'b0;
            acc[k]       = '0;
            nbits[k]     = 0;
        end else begin
            if (sclk && !prev_sclk[k]) begin
                acc[k] = {acc[k][6:0], mosi};
                nbits[k]++;
                rises[k]++;
                if (nbits[k] == 8) begin
                    nbits[k] = 0;
                    if (exp_q.size() == 0) check("extra_byte", int'(acc[k]), -1);
                    else check("byte", int'(acc[k]), int'(exp_q.pop_front()));
                end
            end
            prev_sclk[k] = sclk;
            if (done) begin
                if (done_q.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    check("done_cycle", cyc, done_q.pop_front());
                    check("done_cs_n", int'(cs_n), 1);
                    check("done_ready", int'(ready), 1);
                    check("done_mosi", int'(mosi), 0);
                    check("done_bit_align", nbits[k], 0);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_sclk, a_mosi, a_done, a_cs_n, a_ready);
        mon(1, b_sclk, b_mosi, b_done, b_cs_n, b_ready);
    end

    function automatic logic get_ready(input int k);
        return (k == 0) ? a_ready : b_ready;
    endfunction

    task automatic set_fields(input int k, input logic st, input logic [7:0] v,
                              input logic [6:0] n, input logic [6:0] vel);
        if (k == 0) begin
            a_status = st; a_voice = v; a_note = n; a_vel = vel;
        end else begin
            b_status = st; b_voice = v; b_note = n; b_vel = vel;
        end
    endtask

    // Issues one event, pushes its expected bytes and done cycle, checks the first
    // cycle of the frame, then scrambles the fields to prove they were captured.
    task automatic send(input int k, input logic st, input logic [7:0] v, input logic [6:0] n,
                        input logic [6:0] vel, input logic [31:0] exp_bytes, input int nbytes,
                        input int per_byte, input bit hold);
        int c;
        bit ok;
        @(negedge clk);
        set_fields(k, st, v, n, vel);
        if (k == 0) a_valid = 1'b1; else b_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (get_ready(k)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("ready_timeout", 0, 1);
            if (k == 0) a_valid = 1'b0; else b_valid = 1'b0;
            return;
        end
        c = cyc;
        check("idle_cs_n", int'((k == 0) ? a_cs_n : b_cs_n), 1);
        for (int i = 0; i < nbytes; i++) exp_q.push_back(exp_bytes[31 - 8*i -: 8]);
        done_q.push_back(c + 1 + nbytes * per_byte);
        @(negedge clk);
        check("start_cs_n", int'((k == 0) ? a_cs_n : b_cs_n), 0);
        check("start_ready", int'(get_ready(k)), 0);
        check("start_sclk", int'((k == 0) ? a_sclk : b_sclk), 0);
        check("start_mosi", int'((k == 0) ? a_mosi : b_mosi), 1);
        set_fields(k, ~st, ~v, ~n, ~vel);
        if (!hold) begin
            if (k == 0) a_valid = 1'b0; else b_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && done_q.size() != 0; i++) @(negedge clk);
        if (done_q.size() != 0) begin
            check("done_timeout", done_q.size(), 0);
            done_q.delete();
        end
        repeat (4) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    int r0;

    initial begin
        rises[0] = 0; rises[1] = 0;
        repeat (3) @(negedge clk);
        check("rst_ready", int'(a_ready), 1);
        check("rst_cs_n", int'(a_cs_n), 1);
        check("rst_sclk", int'(a_sclk), 0);
        check("rst_mosi", int'(a_mosi), 0);
        check("rst_done", int'(a_done), 0);
        check("rst_b_ready", int'(b_ready), 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // NOTEON 90 03 3C 64, first SCLK rise CLK_DIV cycles after frame start.
        r0 = rises[0];
        send(0, 1'b1, 8'h03, 7'd60, 7'd100, 32'h90033C64, 4, 72, 1'b0);
        repeat (3) @(negedge clk);
        check("pre_rise_sclk", int'(a_sclk), 0);
        @(negedge clk);
        check("first_rise_sclk", int'(a_sclk), 1);
        wait_idle();
        check("noteon_rises", rises[0] - r0, 32);

        // NOTEOFF 80 05 with note/velocity all ones that must not appear.
        r0 = rises[0];
        send(0, 1'b0, 8'h05, 7'h7F, 7'h7F, 32'h80050000, 2, 72, 1'b0);
        wait_idle();
        check("noteoff_rises", rises[0] - r0, 16);

        // Back-to-back NOTEON with i_valid held across the done edge.
        r0 = rises[0];
        send(0, 1'b1, 8'h11, 7'd64, 7'd1, 32'h90114001, 4, 72, 1'b1);
        send(0, 1'b1, 8'hA5, 7'd69, 7'd127, 32'h90A5457F, 4, 72, 1'b0);
        wait_idle();
        check("b2b_rises", rises[0] - r0, 64);

        // Reset about 100 cycles into a NOTEON frame.
        send(0, 1'b1, 8'h07, 7'd69, 7'd127, 32'h9007457F, 4, 72, 1'b0);
        repeat (98) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        done_q.delete();
        check("abort_sclk", int'(a_sclk), 0);
        check("abort_mosi", int'(a_mosi), 0);
        check("abort_cs_n", int'(a_cs_n), 1);
        check("abort_ready", int'(a_ready), 1);
        check("abort_done", int'(a_done), 0);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        r0 = rises[0];
        send(0, 1'b0, 8'h07, 7'd69, 7'd127, 32'h80070000, 2, 72, 1'b0);
        wait_idle();
        check("post_abort_rises", rises[0] - r0, 16);

        // Fastest timing: 17 cycles per byte, NOTEON done 69 cycles after accept.
        r0 = rises[1];
        send(1, 1'b1, 8'hFF, 7'h7F, 7'h00, 32'h90FF7F00, 4, 17, 1'b0);
        check("fast_first_rise", int'(b_sclk), 0);
        @(negedge clk);
        check("fast_sclk_hi", int'(b_sclk), 1);
        @(negedge clk);
        check("fast_sclk_lo", int'(b_sclk), 0);
        wait_idle();
        check("fast_noteon_rises", rises[1] - r0, 32);
        r0 = rises[1];
        send(1, 1'b0, 8'h42, 7'h55, 7'h2A, 32'h80420000, 2, 17, 1'b0);
        wait_idle();
        check("fast_noteoff_rises", rises[1] - r0, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
